// File: rtl/ccu2_serial_addsub.sv
// Digit-serial add/subtract, 2 bits (one CCU2 slice) per clock with a registered carry.
// DONE pulses WIDTH/2 cycles after accept; START is ignored while BUSY is high (no queuing).
module ccu2_serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             START,
  input  logic             SUB,
  input  logic             CI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF
);

  localparam int SLICES = WIDTH / 2;
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("ccu2_serial_addsub: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-3:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry_q;
  logic [KW-1:0]    k;
  logic             accept, last;
  logic             p0, p1, c1, c2, s0, s1;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) state <= IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (START) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (k == K_LAST) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == RUN);

  // One CCU2 pair: propagate passes the incoming carry, otherwise a generates/kills it.
  assign p0 = a_q[0] ^ b_q[0];
  assign c1 = p0 ? carry_q : a_q[0];
  assign s0 = p0 ^ carry_q;
  assign p1 = a_q[1] ^ b_q[1];
  assign c2 = p1 ? c1 : a_q[1];
  assign s1 = p1 ^ c1;

  // Result fills from the top; after the last slice the LSBs have shifted down into place.
  assign sum_nxt = {s1, s0, sum_sr};

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      k       <= '0;
      S       <= '0;
      CO      <= 1'b0;
      OVF     <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        a_q     <= A;
        b_q     <= B ^ {WIDTH{SUB}};
        carry_q <= CI;
        k       <= '0;
      end else if (state == RUN) begin
        a_q     <= {2'b00, a_q[WIDTH-1:2]};
        b_q     <= {2'b00, b_q[WIDTH-1:2]};
        sum_sr  <= sum_nxt[WIDTH-1:2];
        carry_q <= c2;
        k       <= k + KW'(1);
        if (last) begin
          S    <= sum_nxt;
          CO   <= c2;
          OVF  <= c1 ^ c2;
          DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccu2_serial_addsub.sv
// Bench for ccu2_serial_addsub at WIDTH=8: directed vectors, busy/back-to-back/reset sequences, random ops.
module tb_ccu2_serial_addsub;

  logic       CK = 1'b0;
  logic       CD, START, SUB, CI;
  logic [7:0] A, B;
  logic       BUSY, DONE, CO, OVF;
  logic [7:0] S;

  int tests = 0;
  int fails = 0;

  ccu2_serial_addsub #(.WIDTH(8)) dut (
    .CK(CK), .CD(CD), .START(START), .SUB(SUB), .CI(CI), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .S(S), .CO(CO), .OVF(OVF)
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic       sub;
    logic       ci;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: unsigned sum for S/CO, signed range for OVF.
  task automatic ref_model(input logic sub, input logic ci, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] s, output logic co, output logic ovf);
    logic [7:0] bb;
    int         u, sv;
    bb  = sub ? ~b : b;
    u   = int'(a) + int'(bb) + int'(ci);
    sv  = int'($signed(a)) + int'($signed(bb)) + int'(ci);
    s   = u[7:0];
    co  = u[8];
    ovf = (sv > 127) || (sv < -128);
  endtask

  // Present one op, scramble the operands after accept, wait (bounded) for DONE.
  task automatic do_op(input logic sub, input logic ci, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] s, output logic co, output logic ovf, output int lat);
    @(negedge CK);
    START = 1'b1; SUB = sub; CI = ci; A = a; B = b;
    @(posedge CK);
    #1;
    START = 1'b0; A = 8'($urandom); B = 8'($urandom); SUB = 1'($urandom); CI = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge CK);
      #1;
      lat++;
      if (DONE) break;
    end
    s = S; co = CO; ovf = OVF;
  endtask

  vec_t       vecs[8];
  logic [7:0] s_got, s_exp;
  logic       co_got, ovf_got, co_exp, ovf_exp;
  int         lat, dones, done_at;
  logic       stable;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};

    CD = 1'b1; START = 1'b0; SUB = 1'b0; CI = 1'b0; A = '0; B = '0;
    #12;
    chk("reset outputs", {BUSY, DONE, CO, OVF, S}, 0);
    @(negedge CK);
    CD = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].sub, vecs[i].ci, vecs[i].a, vecs[i].b, s_got, co_got, ovf_got, lat);
      chk($sformatf("vec%0d latency", i), lat, 4);
      chk($sformatf("vec%0d S", i), s_got, vecs[i].s);
      chk($sformatf("vec%0d CO", i), co_got, vecs[i].co);
      chk($sformatf("vec%0d OVF", i), ovf_got, vecs[i].ovf);
    end

    // START held high with operands changing during RUN.
    @(negedge CK);
    START = 1'b1; SUB = 1'b0; CI = 1'b0; A = 8'h10; B = 8'h20;
    @(posedge CK);
    dones = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CK);
      A = 8'($urandom); B = 8'($urandom); SUB = 1'($urandom); CI = 1'($urandom);
      @(posedge CK);
      #1;
      if (DONE) dones++;
    end
    chk("collision done count", dones, 1);
    chk("collision DONE on 4th edge", DONE, 1);
    chk("collision S", S, 8'h30);
    chk("collision CO", CO, 0);

    // Second op accepted in the DONE cycle.
    @(negedge CK);
    A = 8'h33; B = 8'h11; SUB = 1'b1; CI = 1'b1;
    @(posedge CK);
    #1;
    START = 1'b0;
    chk("b2b BUSY after accept", BUSY, 1);
    dones = 0; done_at = 0; stable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CK);
      #1;
      if (DONE) begin dones++; done_at = i; end
      if (i < 4 && S !== 8'h30) stable = 1'b0;
    end
    chk("b2b done count", dones, 1);
    chk("b2b done latency", done_at, 4);
    chk("b2b S held before done", stable, 1);
    chk("b2b S", S, 8'h22);
    chk("b2b CO", CO, 1);

    // Asynchronous clear while slice 2 is in flight.
    @(negedge CK);
    START = 1'b1; SUB = 1'b0; CI = 1'b0; A = 8'hAA; B = 8'h11;
    @(posedge CK);
    #1;
    START = 1'b0;
    @(posedge CK);
    @(posedge CK);
    #3;
    CD = 1'b1;
    #1;
    chk("async clear outputs", {BUSY, DONE, CO, OVF, S}, 0);
    #3;
    CD = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CK);
      #1;
      if (DONE) dones++;
    end
    chk("no DONE after clear", dones, 0);
    do_op(1'b0, 1'b0, 8'h12, 8'h34, s_got, co_got, ovf_got, lat);
    chk("post-clear latency", lat, 4);
    chk("post-clear S", s_got, 8'h46);

    for (int n = 0; n < 10000; n++) begin
      logic       r_sub, r_ci;
      logic [7:0] r_a, r_b;
      r_sub = 1'($urandom); r_ci = 1'($urandom);
      r_a   = 8'($urandom); r_b  = 8'($urandom);
      if (n % 8 == 0) r_a = 8'h80 | 8'($urandom_range(0, 3));
      do_op(r_sub, r_ci, r_a, r_b, s_got, co_got, ovf_got, lat);
      ref_model(r_sub, r_ci, r_a, r_b, s_exp, co_exp, ovf_exp);
      chk($sformatf("rand%0d sub=%0b ci=%0b a=%0h b=%0h lat/co/ovf/s", n, r_sub, r_ci, r_a, r_b),
          {lat[7:0], 6'b0, co_got, ovf_got, s_got}, {8'd4, 6'b0, co_exp, ovf_exp, s_exp});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
